bridge_request_arbiter: RTL and testbench

BRIDGE_REQUEST_ARBITER -- requirements
Module: bridge_request_arbiter

---
 rtl/bridge_request_arbiter_if.sv | 39 +++
 rtl/bridge_request_arbiter.sv | 111 +++++++++++
 tb/tb_bridge_request_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_request_arbiter_if.sv
// Bundles the requester-side and driver-side signals of the bridge request arbiter.
// The master modport is the arbiter itself (it masters the driver channel);
// the slave modport is the surrounding requesters plus bridge driver.
interface bridge_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0][15:0]    req_word;
  logic [NUM_REQ-1:0][127:0]   req_param;
  logic [NUM_REQ-1:0]          req_grant;
  logic [NUM_REQ-1:0]          req_done;
  logic [15:0]                 req_progress;
  logic [15:0]                 req_result;
  logic [127:0]                req_response;
  logic                        drv_valid;
  logic [15:0]                 drv_word;
  logic [127:0]                drv_param;
  logic [15:0]                 drv_progress;
  logic                        drv_done;
  logic [15:0]                 drv_result;
  logic [127:0]                drv_response;
  logic                        busy;
  logic [IDX_W-1:0]            grant_id;

  modport master (
    input  req_valid, req_word, req_param,
           drv_progress, drv_done, drv_result, drv_response,
    output req_grant, req_done, req_progress, req_result, req_response,
           drv_valid, drv_word, drv_param, busy, grant_id
  );

  modport slave (
    output req_valid, req_word, req_param,
           drv_progress, drv_done, drv_result, drv_response,
    input  req_grant, req_done, req_progress, req_result, req_response,
           drv_valid, drv_word, drv_param, busy, grant_id
  );
endinterface

// File: rtl/bridge_request_arbiter.sv
// Round-robin arbiter sharing one bridge-driver command channel among NUM_REQ requesters.
// Latency: req_valid seen in IDLE at cycle T gives drv_valid at T+1; req_done the cycle after drv_done.
// Backpressure: level requests wait in IDLE while a command is in flight; no buffering.
module bridge_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  bridge_request_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_found;
  logic [IDX_W-1:0] rr_nxt;

  // Pick the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pointer moves to the requester just after the one that finished.
  always_comb begin
    rr_nxt = (grant_id_is_last()) ? '0 : bus.grant_id + 1'b1;
  end

  function automatic logic grant_id_is_last();
    return bus.grant_id == IDX_W'(NUM_REQ - 1);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; drv_valid is a single-cycle pulse confined to ISSUE.
  always_comb begin
    state_nxt     = state;
    bus.drv_valid = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE:    if (sel_found) state_nxt = ISSUE;
      ISSUE: begin
        bus.drv_valid = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT:    if (bus.drv_done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the winner's command, track progress, capture the completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr           <= '0;
      bus.grant_id     <= '0;
      bus.req_grant    <= '0;
      bus.req_done     <= '0;
      bus.req_progress <= '0;
      bus.req_result   <= '0;
      bus.req_response <= '0;
      bus.drv_word     <= '0;
      bus.drv_param    <= '0;
    end else begin
      bus.req_done <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            bus.grant_id  <= sel_idx;
            bus.req_grant <= ONE_HOT0 << sel_idx;
            bus.drv_word  <= bus.req_word[sel_idx];
            bus.drv_param <= bus.req_param[sel_idx];
          end
        end
        WAIT: begin
          bus.req_progress <= bus.drv_progress;
          if (bus.drv_done) begin
            bus.req_result   <= bus.drv_result;
            bus.req_response <= bus.drv_response;
            bus.req_done     <= ONE_HOT0 << bus.grant_id;
          end
        end
        RELEASE: begin
          bus.req_grant <= '0;
          rr_ptr        <= rr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_request_arbiter.sv
// Randomised bench for bridge_request_arbiter: a schedule-based model predicts every
// grant and completion (with its cycle); a negedge monitor pops and compares them.
module tb_bridge_request_arbiter;
  localparam int N = 4;

  typedef struct packed {
    int           id;
    logic [15:0]  w;
    logic [127:0] p;
    int           cyc;
  } gexp_t;

  typedef struct packed {
    int           id;
    logic [15:0]  r;
    logic [127:0] resp;
    int           cyc;
  } cexp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bridge_request_arbiter_if #(.NUM_REQ(N)) bus ();
  bridge_request_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // model state
  gexp_t        gq[$];
  cexp_t        cq[$];
  int           st[N];          // 0 idle, 1 pending, 2 owner
  int           own = -1;
  int           g_cyc = 0;
  int           d_cyc = 0;
  int           rr_m = 0;
  int           t_dec = 1;
  logic [15:0]  prog_m = '0;
  logic [15:0]  exp_prog = '0;
  logic [15:0]  cur_res;
  logic [127:0] cur_resp;
  bit           fix_en = 1'b0;
  logic [15:0]  fix_res = '0;
  int           fix_dly = -1;
  logic [N-1:0] pre_mask = '0;
  logic [15:0]  pre_word[N];
  logic [127:0] pre_param[N];
  logic [15:0]  hold_w = '0;
  logic [127:0] hold_p = '0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic raise(input int i, input logic [15:0] w, input logic [127:0] p);
    bus.req_valid[i] = 1'b1;
    bus.req_word[i]  = w;
    bus.req_param[i] = p;
    st[i] = 1;
  endtask

  // One clock of stimulus plus the schedule model.
  task automatic step(input int p_req, input bit rst_now);
    bit in_wait;
    int pick;
    int dly;
    @(posedge clk); #1;
    cyc++;
    mon_en   = 1'b1;
    reset    = rst_now;
    exp_prog = prog_m;
    if (own >= 0) begin
      if (cyc == d_cyc + 1) begin
        bus.req_valid[own] = 1'b0;
        st[own] = 0;
        own = -1;
      end else if (cyc > g_cyc) begin
        if ($urandom_range(7) == 0) bus.req_valid[own] = 1'b0;
        if ($urandom_range(3) == 0) begin
          bus.req_word[own]  = 16'($urandom);
          bus.req_param[own] = rnd128();
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (pre_mask[i]) raise(i, pre_word[i], pre_param[i]);
    pre_mask = '0;
    for (int i = 0; i < N; i++)
      if (st[i] == 0 && int'($urandom_range(99)) < p_req) raise(i, 16'($urandom), rnd128());
    if (cyc == t_dec) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && st[(rr_m + k) % N] == 1) pick = (rr_m + k) % N;
      if (pick >= 0) begin
        dly      = (fix_dly >= 0) ? fix_dly : int'($urandom_range(5));
        own      = pick;
        st[pick] = 2;
        g_cyc    = cyc;
        d_cyc    = cyc + 2 + dly;
        cur_res  = fix_en ? fix_res : 16'($urandom);
        cur_resp = rnd128();
        gq.push_back('{pick, bus.req_word[pick], bus.req_param[pick], cyc + 1});
        cq.push_back('{pick, cur_res, cur_resp, d_cyc + 1});
        rr_m  = (pick + 1) % N;
        t_dec = d_cyc + 2;
      end else begin
        t_dec = cyc + 1;
      end
    end
    in_wait = (own >= 0) && (cyc >= g_cyc + 2) && (cyc <= d_cyc);
    bus.drv_progress = 16'($urandom);
    if (own >= 0 && cyc == d_cyc) begin
      bus.drv_done     = 1'b1;
      bus.drv_result   = cur_res;
      bus.drv_response = cur_resp;
    end else begin
      bus.drv_done     = !in_wait && !rst_now && ($urandom_range(9) == 0);
      bus.drv_result   = 16'($urandom);
      bus.drv_response = rnd128();
    end
    if (in_wait) prog_m = bus.drv_progress;
    if (rst_now) begin
      if (own >= 0 && cq.size() > 0) cq.delete(cq.size() - 1);
      own = -1;
      for (int i = 0; i < N; i++) begin
        st[i] = 0;
        bus.req_valid[i] = 1'b0;
      end
      rr_m   = 0;
      prog_m = '0;
      t_dec  = cyc + 1;
    end
  endtask

  task automatic drain();
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 300) begin
      step(0, 1'b0);
      n++;
      pend = (own >= 0) || (gq.size() != 0) || (cq.size() != 0);
      for (int i = 0; i < N; i++) if (st[i] != 0) pend = 1'b1;
    end
    chk("drain_timeout", 128'(pend), 128'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_grant"},    bus.req_grant,    '0);
    chk({tag, "_req_done"},     bus.req_done,     '0);
    chk({tag, "_drv_valid"},    bus.drv_valid,    '0);
    chk({tag, "_busy"},         bus.busy,         '0);
    chk({tag, "_grant_id"},     bus.grant_id,     '0);
    chk({tag, "_req_progress"}, bus.req_progress, '0);
    chk({tag, "_req_result"},   bus.req_result,   '0);
    chk({tag, "_req_response"}, bus.req_response, '0);
    chk({tag, "_drv_word"},     bus.drv_word,     '0);
    chk({tag, "_drv_param"},    bus.drv_param,    '0);
  endtask

  // Monitor: compare whatever the DUT presents against the predicted queues.
  always @(negedge clk) begin
    gexp_t ge;
    cexp_t ce;
    if (mon_en) begin
      chk("req_progress", bus.req_progress, exp_prog);
      if (bus.drv_valid) begin
        if (gq.size() == 0) chk("unexpected_drv_valid", bus.drv_valid, 0);
        else begin
          ge = gq.pop_front();
          chk("grant_cycle", cyc, ge.cyc);
          chk("grant_id",    bus.grant_id, ge.id);
          chk("req_grant",   bus.req_grant, N'(1) << ge.id);
          chk("drv_word",    bus.drv_word, ge.w);
          chk("drv_param",   bus.drv_param, ge.p);
          hold_w = ge.w;
          hold_p = ge.p;
        end
      end else begin
        chk("drv_word_hold",  bus.drv_word, hold_w);
        chk("drv_param_hold", bus.drv_param, hold_p);
      end
      if (bus.req_done != '0) begin
        if (cq.size() == 0) chk("unexpected_req_done", bus.req_done, 0);
        else begin
          ce = cq.pop_front();
          chk("done_cycle",   cyc, ce.cyc);
          chk("req_done",     bus.req_done, N'(1) << ce.id);
          chk("req_result",   bus.req_result, ce.r);
          chk("req_response", bus.req_response, ce.resp);
        end
      end
      if (reset) begin
        hold_w = '0;
        hold_p = '0;
      end
    end
  end

  initial begin
    int n;
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.req_word     = '0;
    bus.req_param    = '0;
    bus.drv_progress = '0;
    bus.drv_done     = 1'b0;
    bus.drv_result   = '0;
    bus.drv_response = '0;
    for (int i = 0; i < N; i++) st[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");

    // everyone requesting continuously: round-robin 0,1,2,3,0,...
    repeat (300) step(100, 1'b0);
    drain();

    // single requester 2 with known word/param/result
    fix_en = 1'b1; fix_res = 16'h0007;
    pre_word[2] = 16'h0042; pre_param[2] = 128'h1; pre_mask = 4'b0100;
    drain();
    fix_en = 1'b0;
    chk("dir_req_result", bus.req_result, 16'h0007);

    // mixed random traffic
    repeat (800) step(20, 1'b0);
    repeat (400) step(5, 1'b0);
    drain();

    // reset in WAIT, then 0 and 3 request together: 0 must win
    fix_dly = 5;
    pre_word[1] = 16'h1111; pre_param[1] = 128'h5; pre_mask = 4'b0010;
    n = 0;
    step(0, 1'b0);
    while (!(own == 1 && cyc == g_cyc + 2) && n < 50) begin
      step(0, 1'b0);
      n++;
    end
    chk("reach_wait_timeout", 128'(n >= 50), 128'(0));
    step(0, 1'b1);
    step(0, 1'b0);
    @(negedge clk);
    chk_reset_vals("midreset");
    fix_dly = -1;
    pre_word[0] = 16'hA0A0; pre_param[0] = 128'hA;
    pre_word[3] = 16'h3B3B; pre_param[3] = 128'hB;
    pre_mask = 4'b1001;
    drain();

    repeat (3) step(0, 1'b0);
    chk("grant_queue_left", gq.size(), 0);
    chk("done_queue_left",  cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
